// File: rtl/axis_red_pitaya_dac_pkg.sv
// ---------------------------------------------------------------------------
// axis_red_pitaya_dac_pkg
// Shared constants and types for the Red Pitaya DAC stream sink.
//   DAC_DATA_WIDTH     : width of the DAC code bus
//   DAC_MIDSCALE       : DAC code for a sample value of 0
//   UNDERRUN_CNT_WIDTH : width of the saturating underrun counter
//   SAMPLE_WIDTH       : width of one signed channel sample in the stream
//   SAT_MAX / SAT_MIN  : signed 14-bit clamp limits applied to samples
//   dac_state_t        : sequencing state (IDLE / WARMUP / RUN)
// ---------------------------------------------------------------------------
package axis_red_pitaya_dac_pkg;

  localparam int DAC_DATA_WIDTH     = 14;
  localparam int UNDERRUN_CNT_WIDTH = 16;
  localparam int SAMPLE_WIDTH       = 16;

  localparam logic [DAC_DATA_WIDTH-1:0] DAC_MIDSCALE = 14'h1FFF;

  localparam logic signed [SAMPLE_WIDTH-1:0] SAT_MAX = 16'sd8191;
  localparam logic signed [SAMPLE_WIDTH-1:0] SAT_MIN = -16'sd8192;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } dac_state_t;

endpackage

// File: rtl/axis_red_pitaya_dac_v2_fmt.sv
// ---------------------------------------------------------------------------
// dac_sample_fmt
// Purely combinational conversion of one signed 16-bit sample into a DAC code.
// The sample is clamped to the signed 14-bit range, then mapped so that
// +8191 -> 0x0000, 0 -> 0x1FFF, -1 -> 0x2000, -8192 -> 0x3FFF
// (MSB kept, lower bits inverted: the inverse of the ADC-side mapping).
// Ports:
//   i_sample : signed 16-bit sample (two's complement)
//   o_code   : DAC code, DAC_DATA_WIDTH bits
// ---------------------------------------------------------------------------
module dac_sample_fmt
  import axis_red_pitaya_dac_pkg::*;
(
  input  logic [SAMPLE_WIDTH-1:0]   i_sample,
  output logic [DAC_DATA_WIDTH-1:0] o_code
);

  logic signed [SAMPLE_WIDTH-1:0] w_s;
  logic [DAC_DATA_WIDTH-1:0]      w_sat;

  assign w_s = i_sample;

  always_comb begin
    w_sat = w_s[DAC_DATA_WIDTH-1:0];
    if (w_s > SAT_MAX) begin
      w_sat = SAT_MAX[DAC_DATA_WIDTH-1:0];
    end else if (w_s < SAT_MIN) begin
      w_sat = SAT_MIN[DAC_DATA_WIDTH-1:0];
    end
  end

  assign o_code = {w_sat[DAC_DATA_WIDTH-1], ~w_sat[DAC_DATA_WIDTH-2:0]};

endmodule

// File: rtl/axis_red_pitaya_dac_v2.sv
// ---------------------------------------------------------------------------
// axis_red_pitaya_dac_v2
// AXI-Stream slave feeding the time-interleaved Red Pitaya DAC bus. One beat
// carries {B,A} signed 16-bit samples; A is driven on the even clock
// (dac_sel=1), B on the odd clock (dac_sel=0), so a beat is consumed every
// two clocks. After enable rises the DAC leaves reset and is held at
// midscale for WARMUP_CYCLES clocks before the stream is consumed. Missing
// beats are counted as underruns.
// Ports:
//   aclk, areset    : clock, asynchronous active-high reset
//   enable          : 1 = stream to DAC, 0 = idle
//   s_axis_tdata    : packed {B[31:16], A[15:0]} samples
//   s_axis_tvalid   : slave valid
//   s_axis_tready   : slave ready (from registers only, never from tvalid)
//   dac_dat         : registered DAC code
//   dac_sel         : 1 = dac_dat carries channel A, 0 = channel B
//   dac_wrt         : DAC write strobe
//   dac_rst         : DAC reset, active-high
//   underrun        : sticky underrun flag (cleared when enable starts a run)
//   underrun_cnt    : saturating underrun count
// Parameters:
//   AXIS_TDATA_WIDTH : stream width (two 16-bit channels)
//   WARMUP_CYCLES    : midscale clocks after the DAC leaves reset
//   UNDERRUN_ZERO    : 1 = substitute zero on underrun, 0 = repeat last pair
// ---------------------------------------------------------------------------
module axis_red_pitaya_dac_v2
  import axis_red_pitaya_dac_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int WARMUP_CYCLES    = 16,
  parameter int UNDERRUN_ZERO    = 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          enable,
  input  logic [AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [DAC_DATA_WIDTH-1:0]     dac_dat,
  output logic                          dac_sel,
  output logic                          dac_wrt,
  output logic                          dac_rst,
  output logic                          underrun,
  output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_cnt
);

  localparam int WARM_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYCLES - 1);
  localparam logic [UNDERRUN_CNT_WIDTH-1:0] CNT_MAX = '1;

  dac_state_t r_state;
  dac_state_t w_state_next;

  logic                          r_phase;
  logic [WARM_W-1:0]             r_warm_cnt;
  logic [AXIS_TDATA_WIDTH-1:0]   r_sample;
  logic [DAC_DATA_WIDTH-1:0]     r_dac_dat;
  logic                          r_dac_sel;
  logic                          r_underrun;
  logic [UNDERRUN_CNT_WIDTH-1:0] r_underrun_cnt;

  logic                          w_tready;
  logic                          w_dac_rst;
  logic                          w_dac_wrt;
  logic                          w_accept;
  logic                          w_starve;
  logic [DAC_DATA_WIDTH-1:0]     w_code [2];

  // One formatter per channel; the phase picks which code is registered.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      dac_sample_fmt u_fmt (
        .i_sample (r_sample[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
        .o_code   (w_code[gi])
      );
    end
  endgenerate

  // ---------------- FSM: state register ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (enable) w_state_next = WARMUP;
      end
      WARMUP: begin
        if (!enable) begin
          w_state_next = IDLE;
        end else if ((r_warm_cnt == WARM_LAST) && r_phase) begin
          // Leave on an odd clock so RUN always starts on an A slot.
          w_state_next = RUN;
        end
      end
      RUN: begin
        // Disable takes effect only once the B slot of the pair is issued.
        if (r_phase && !enable) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_dac_rst = 1'b1;
    w_dac_wrt = 1'b0;
    w_tready  = 1'b0;
    case (r_state)
      WARMUP: begin
        w_dac_rst = 1'b0;
        w_dac_wrt = 1'b1;
      end
      RUN: begin
        w_dac_rst = 1'b0;
        w_dac_wrt = 1'b1;
        w_tready  = r_phase & enable;
      end
      default: ;
    endcase
  end

  assign w_accept = w_tready & s_axis_tvalid;
  assign w_starve = w_tready & ~s_axis_tvalid;

  // ---------------- datapath ----------------
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_phase        <= 1'b0;
      r_warm_cnt     <= '0;
      r_sample       <= '0;
      r_dac_dat      <= DAC_MIDSCALE;
      r_dac_sel      <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_phase <= (r_state == IDLE) ? 1'b0 : ~r_phase;

      if (r_state == WARMUP) begin
        if (r_warm_cnt != WARM_LAST) r_warm_cnt <= r_warm_cnt + 1'b1;
      end else begin
        r_warm_cnt <= '0;
      end

      case (r_state)
        IDLE: begin
          r_dac_dat <= DAC_MIDSCALE;
          r_dac_sel <= 1'b0;
          if (enable) begin
            // A new run starts with clean status and no stale sample pair.
            r_sample       <= '0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
          end
        end
        WARMUP: begin
          r_dac_dat <= DAC_MIDSCALE;
          r_dac_sel <= ~r_phase;
        end
        RUN: begin
          r_dac_dat <= r_phase ? w_code[1] : w_code[0];
          r_dac_sel <= ~r_phase;
          if (w_accept) begin
            r_sample <= s_axis_tdata;
          end else if (w_starve) begin
            if (UNDERRUN_ZERO != 0) r_sample <= '0;
            r_underrun <= 1'b1;
            if (r_underrun_cnt != CNT_MAX) r_underrun_cnt <= r_underrun_cnt + 1'b1;
          end
        end
        default: begin
          r_dac_dat <= DAC_MIDSCALE;
          r_dac_sel <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = w_tready;
  assign dac_dat       = r_dac_dat;
  assign dac_sel       = r_dac_sel;
  assign dac_wrt       = w_dac_wrt;
  assign dac_rst       = w_dac_rst;
  assign underrun      = r_underrun;
  assign underrun_cnt  = r_underrun_cnt;

endmodule

// File: doc/axis_red_pitaya_dac_v2.md
Name: axis_red_pitaya_dac_v2

Overview:
- Transmit-side counterpart of the Red Pitaya ADC stream path: AXI-Stream slave that accepts packed two-channel samples and drives the 14-bit DAC bus.
- Sits between the OFDM TX datapath (IFFT/CP output) and the DAC pins.
- Single-clock model: channels A and B are time-interleaved on one bus with a select line, so one AXIS beat is consumed every two clocks.
- Also performs saturation, DAC code conversion, start-up sequencing and underrun accounting.

Parameters:
- DAC_DATA_WIDTH, 14, DAC code width.
- AXIS_TDATA_WIDTH, 32, stream width. Channel A is [15:0], channel B is [31:16], both signed 16-bit.
- WARMUP_CYCLES, 16, clocks at midscale after the DAC leaves reset, before the stream is consumed.
- UNDERRUN_ZERO, 1, on underrun: 1 = substitute sample 0, 0 = repeat the last sample pair.

Ports:
- aclk  in  1  system clock
- areset  in  1  asynchronous reset, active-high
- enable  in  1  level; 1 = stream to DAC, 0 = idle
- s_axis_tdata  in  AXIS_TDATA_WIDTH  packed {B,A} samples
- s_axis_tvalid  in  1  slave valid
- s_axis_tready  out  1  slave ready
- dac_dat  out  DAC_DATA_WIDTH  DAC code (registered)
- dac_sel  out  1  1 = dac_dat carries channel A, 0 = channel B
- dac_wrt  out  1  DAC write strobe
- dac_rst  out  1  DAC reset, active-high
- underrun  out  1  sticky underrun flag
- underrun_cnt  out  16  saturating underrun count

Behaviour:
- Reset (areset=1, immediate, also mid-operation):
  - state=IDLE, phase=0, sample_reg=0.
  - dac_dat=0x1FFF (code for 0), dac_sel=0, dac_wrt=0, dac_rst=1, s_axis_tready=0, underrun=0, underrun_cnt=0.
- States:
  - IDLE:
    - dac_rst=1, dac_wrt=0, dac_dat=0x1FFF.
    - enable=1 → WARMUP. This transition also clears underrun and underrun_cnt.
  - WARMUP:
    - dac_rst=0, dac_wrt=1, dac_dat=0x1FFF; phase toggles every clock.
    - Counter runs 0..WARMUP_CYCLES-1.
    - At terminal count with phase=1 → RUN.
    - enable=0 → IDLE.
  - RUN:
    - phase toggles every clock; dac_wrt=1.
    - When enable=0 is sampled at phase=1 → IDLE after the current pair. No beat is accepted on that edge.
- Handshake:
  - s_axis_tready = (state==RUN) & (phase==1) & enable. Combinational from registers only; never depends on tvalid.
  - Transfer occurs at an edge where tvalid & tready are both 1; sample_reg <= tdata.
- Underrun:
  - Occurs in RUN at a phase=1 edge with tvalid=0.
  - sample_reg <= 0 if UNDERRUN_ZERO, else it holds.
  - underrun <= 1; underrun_cnt increments and saturates at 0xFFFF.
- Output register (every edge in RUN):
  - dac_dat <= fmt(phase==0 ? sample_reg[15:0] : sample_reg[31:16]).
  - dac_sel <= (phase==0).
- Latency:
  - Beat accepted at edge E: channel A is on dac_dat after E+1 (dac_sel=1), channel B after E+2 (dac_sel=0).
  - Sustained throughput is 1 beat per 2 clocks, with no bubbles while tvalid stays high.
- fmt():
  - Saturate signed 16-bit to signed 14-bit: >8191 → 8191, <-8192 → -8192.
  - Code = {s[13], ~s[12:0]}, the inverse of the ADC-side mapping.
  - 0 → 0x1FFF, 8191 → 0x0000, -8192 → 0x3FFF, -1 → 0x2000.
- Simultaneous events:
  - enable falling at the same phase=1 edge where tvalid=1: no transfer, no underrun count.
  - areset overrides everything.

Decomposition:
- Package axis_red_pitaya_dac_pkg holds:
  - DAC_DATA_WIDTH
  - DAC_MIDSCALE=14'h1FFF
  - state encoding IDLE/WARMUP/RUN
  - UNDERRUN_CNT_WIDTH=16
- Sub-module dac_sample_fmt: purely combinational 16-bit signed → 14-bit DAC code (saturate + map). Instantiated twice (A and B) or once behind the phase mux.

Test Plan:
- Reset/warmup:
  - Stimulus: areset pulse, then enable=1.
  - Required: dac_rst=1 in IDLE and 0 in WARMUP; dac_dat=0x1FFF for 16 clocks; s_axis_tready first rises at a phase=1 cycle after warmup.
- Streaming:
  - Stimulus: beats 0x0064_FF9C (B=100, A=-100), then 0x1FFF_E000, with tvalid always 1.
  - Required: dac_dat sequence 0x2063(sel=1), 0x1F9B(sel=0), 0x3FFF(sel=1), 0x0000(sel=0); tready high every second clock.
- Saturation:
  - Stimulus: A=0x7FFF, B=0x8000.
  - Required: dac_dat = 0x0000 then 0x3FFF.
- Underrun:
  - Stimulus: with UNDERRUN_ZERO=1, drop tvalid for 3 phase=1 edges.
  - Required: dac_dat=0x1FFF for 6 clocks; underrun=1; underrun_cnt=3.
  - Stimulus: repeat with UNDERRUN_ZERO=0.
  - Required: the last pair repeats.
- Disable and mid-operation reset:
  - Stimulus: enable=0 mid-stream.
  - Required: the current B slot completes; no further tready; state IDLE with dac_dat=0x1FFF.
  - Stimulus: assert areset mid-RUN.
  - Required: outputs reach reset values without waiting for an aclk edge.
